// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built from one full-adder cell and
// a registered carry. Operands are consumed LSB first, one bit per clock, and
// the result is published on sum/cout with a single-cycle done pulse.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // One extra bit beyond clog2 so the counter can never wrap before the last bit.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             s_bit;
  logic             c_next;

  // The single full-adder cell working on the current LSBs and the stored carry.
  always_comb begin
    s_bit  = a_sh[0] ^ b_sh[0] ^ c;
    c_next = (a_sh[0] & b_sh[0]) | (c & (a_sh[0] ^ b_sh[0]));
  end

  // Control FSM and datapath; sum/cout only move on the edge that raises done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            c     <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ADD;
          end
        end
        ADD: begin
          c    <= c_next;
          s_sh <= {s_bit, s_sh[WIDTH-1:1]};
          a_sh <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh <= {1'b0, b_sh[WIDTH-1:1]};
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum   <= {s_bit, s_sh[WIDTH-1:1]};
            cout  <= c_next;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: table-driven checks of an 8-bit serial_adder plus
// hand-written corner sequences, and an exhaustive sweep of a 4-bit build.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;

  logic       start8;
  logic [7:0] a8, b8;
  logic       cin8;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start4;
  logic [3:0] a4, b4;
  logic       cin4;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a_in(a4), .b_in(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] expSum;
    logic       expCout;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Runs one 8-bit add; optionally pulses start (with new operands) mid-operation.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic ci,
                               input bit glitchStart,
                               output logic [7:0] s, output logic co);
    logic [7:0] prevSum;
    logic       prevCout;
    int         cycles;
    int         busyCycles;
    prevSum  = sum8;
    prevCout = cout8;
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; cin8 = ci;
    @(negedge clk);
    start8 = 1'b0; a8 = ~a; b8 = a ^ b; cin8 = ~ci;
    cycles = 0;
    busyCycles = 0;
    while (!done8 && cycles < 50) begin
      if (busy8) busyCycles++;
      checkOutput("sum_hold", {24'd0, sum8}, {24'd0, prevSum});
      checkOutput("cout_hold", {31'd0, cout8}, {31'd0, prevCout});
      if (glitchStart && cycles == 3) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    start8 = 1'b0;
    checkOutput("latency8", cycles, 8);
    if (busy8) busyCycles++;
    s  = sum8;
    co = cout8;
    @(negedge clk);
    checkOutput("done_width", {31'd0, done8}, 32'd0);
    checkOutput("busy_idle", {31'd0, busy8}, 32'd0);
    checkOutput("busy_cycles", busyCycles, 9);
  endtask

  // Runs one 4-bit add and reports the number of edges until done.
  task automatic runAdd4(input logic [3:0] a, input logic [3:0] b, input logic ci,
                         output logic [3:0] s, output logic co, output int cycles);
    @(negedge clk);
    start4 = 1'b1; a4 = a; b4 = b; cin4 = ci;
    @(negedge clk);
    start4 = 1'b0; a4 = ~a; b4 = ~b; cin4 = ~ci;
    cycles = 0;
    while (!done4 && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
    s  = sum4;
    co = cout4;
    @(negedge clk);
  endtask

  // Main test sequence.
  initial begin
    logic [7:0] s;
    logic       co;
    logic [3:0] s4;
    logic       co4;
    int         cyc;
    int         sawDone;
    logic [4:0] expect4;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0};
    vecs[3] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[5] = '{8'h0F, 8'h01, 1'b1, 8'h11, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[7] = '{8'h55, 8'h22, 1'b0, 8'h77, 1'b0};

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", {31'd0, busy8}, 32'd0);
    checkOutput("reset_done", {31'd0, done8}, 32'd0);
    checkOutput("reset_sum", {24'd0, sum8}, 32'd0);
    checkOutput("reset_cout", {31'd0, cout8}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] table-driven vectors");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].ci, 1'b0, s, co);
      checkOutput($sformatf("vec%0d_sum", i), {24'd0, s}, {24'd0, vecs[i].expSum});
      checkOutput($sformatf("vec%0d_cout", i), {31'd0, co}, {31'd0, vecs[i].expCout});
    end

    $display("[TB] start pulsed while busy");
    applyStimulus(8'h12, 8'h34, 1'b0, 1'b1, s, co);
    checkOutput("ignore_start_sum", {24'd0, s}, 32'h46);
    checkOutput("ignore_start_cout", {31'd0, co}, 32'd0);
    sawDone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 || busy8) sawDone++;
    end
    checkOutput("no_queued_op", sawDone, 0);

    $display("[TB] reset mid-operation");
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", {31'd0, busy8}, 32'd0);
    checkOutput("abort_sum", {24'd0, sum8}, 32'd0);
    checkOutput("abort_cout", {31'd0, cout8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sawDone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done8) sawDone++;
    end
    checkOutput("abort_no_done", sawDone, 0);
    applyStimulus(8'h80, 8'h80, 1'b0, 1'b0, s, co);
    checkOutput("after_abort_sum", {24'd0, s}, 32'h00);
    checkOutput("after_abort_cout", {31'd0, co}, 32'd1);

    $display("[TB] exhaustive 4-bit sweep");
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int ci = 0; ci < 2; ci++) begin
          runAdd4(4'(a), 4'(b), 1'(ci), s4, co4, cyc);
          expect4 = 5'(a + b + ci);
          checkOutput($sformatf("w4_%0d_%0d_%0d", a, b, ci), {27'd0, co4, s4}, {27'd0, expect4});
          checkOutput("w4_latency", cyc, 4);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around a single full-adder cell plus a registered carry.
- Consumes the cell's sum/carry each clock and processes operands LSB first, one bit per cycle.
- Sits directly downstream of the combinational full adder. It is the sequential wrapper that turns the 1-bit cell into a multi-bit add with a start/done handshake.
- Area-minimal alternative to a ripple-carry adder for lab datapaths.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a_in  input  WIDTH  operand A, captured on the accepted start
- b_in  input  WIDTH  operand B, captured on the accepted start
- cin  input  1  carry-in, captured on the accepted start
- busy  output  1  high while in ADD or DONE
- done  output  1  one-cycle pulse: result valid
- sum  output  WIDTH  registered result, held until the next completion
- cout  output  1  registered final carry, held with sum

Behaviour:
- Reset: clk and rst_n form the single clock domain. Reset is asynchronous and active-low.
  - On rst_n=0: state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry register and bit counter are cleared.
  - Reset asserted mid-operation aborts the add. No done pulse is produced, and sum/cout go to 0.
- State machine, states IDLE, ADD, DONE; transitions on rising clk edges:
  - IDLE: if start=1, load a_sh<=a_in, b_sh<=b_in, c<=cin, cnt<=0, and go to ADD. Otherwise stay.
  - ADD, every cycle:
    - s = a_sh[0]^b_sh[0]^c
    - c <= (a_sh[0]&b_sh[0]) | (c&(a_sh[0]^b_sh[0]))
    - s_sh <= {s, s_sh[WIDTH-1:1]}
    - a_sh and b_sh shift right by one, cnt<=cnt+1
    - When cnt==WIDTH-1, this last bit is processed and the next state is DONE. On that same edge: sum<={s, s_sh[WIDTH-1:1]}, cout<=the new carry, done<=1.
  - DONE: lasts one cycle. done is cleared on the next edge, and the state returns to IDLE.
- Latency:
  - Exactly WIDTH ADD cycles per operation.
  - done is high during the cycle that starts WIDTH edges after the edge that accepted start.
  - Back-to-back throughput: one result per WIDTH+2 cycles.
- Handshake:
  - start is ignored in ADD and DONE. No queuing and no effect on the operation in flight.
  - A start held continuously is re-accepted on the first IDLE cycle.
- Operand stability: a_in, b_in and cin may change freely after the accepted start. Only the values captured at acceptance are used.
- Output stability:
  - sum/cout change only on the edge that raises done (or on reset).
  - Partial results are never visible on sum or cout.
- Arithmetic: {cout,sum} == a+b+cin, computed modulo 2^(WIDTH+1). Overflow appears only in cout.
- busy=1 from the edge after start is accepted through the DONE cycle. busy=0 in IDLE.
- cnt width: clog2(WIDTH)+1 bits. It must not wrap before reaching WIDTH-1.

Test Plan (WIDTH=8 unless stated):
1. 0x00+0x00, cin=0 -> done after 8 ADD cycles; sum=0x00, cout=0. busy=1 for exactly 9 cycles; done=1 for exactly 1 cycle.
2. 0xFF+0x01, cin=0 -> sum=0x00, cout=1. Then 0x3C+0x42, cin=0 -> sum=0x7E, cout=0. sum stays at 0x00 throughout the second add until its done edge.
3. 0xA5+0x5A, cin=1 -> sum=0x00, cout=1 (0xFF+1 carries through all bits).
4. Start accepted with 0x12+0x34. Pulse start again with 0xFF+0xFF while busy, and change a_in/b_in mid-operation -> single done, sum=0x46, cout=0. The second start produces no effect.
5. Start 0x80+0x80; drive rst_n low for 1 cycle, 4 cycles into ADD -> busy=0, sum=0, cout=0 immediately. No done pulse. A subsequent 0x80+0x80 completes with sum=0x00, cout=1.
6. WIDTH=4 build, exhaustive over a, b in 0..15 and cin in {0,1} -> each {cout,sum} equals a+b+cin. done appears exactly 4 edges after the accepted start.
